div_unit: RTL

//  Iterative RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring, one quotient bit per cycle.

---
 rtl/div_if.sv | 19 +
 rtl/div_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/div_if.sv
// Request/response bundle between the issuing pipeline and the iterative divider.
interface div_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [1:0]            op;
  logic [4:0]            rd_in;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [4:0]            rw_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output start, op, rd_in, dividend, divisor, kill,
                  input  busy, done, wr_en, rw_addr, wr_data);
  modport slave  (input  start, op, rd_in, dividend, divisor, kill,
                  output busy, done, wr_en, rw_addr, wr_data);
endinterface

// File: rtl/div_unit.sv
// RV32M divider: radix-2 restoring, one quotient bit per cycle on magnitudes,
// with sign fix-up folded into the final step so the result registers on entry to DONE.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rem, quo, dvsr;
  logic           neg_q, neg_r, is_rem;
  logic [4:0]     rd;

  // start-time decode
  logic         sgn, a_neg, b_neg, div0, ovf;
  logic [W-1:0] a_abs, b_abs;

  always_comb begin
    sgn   = ~bus.op[0];
    a_neg = sgn & bus.dividend[W-1];
    b_neg = sgn & bus.divisor[W-1];
    a_abs = a_neg ? -bus.dividend : bus.dividend;
    b_abs = b_neg ? -bus.divisor  : bus.divisor;
    div0  = (bus.divisor == '0);
    ovf   = sgn && (bus.dividend == {1'b1, {(W-1){1'b0}}}) && (bus.divisor == '1);
  end

  // one shift-subtract step plus the signed result of that step
  logic [W:0]   shifted, trial;
  logic [W-1:0] rem_n, quo_n, q_fix, r_fix, res;

  always_comb begin
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, dvsr};
    if (trial[W]) begin
      rem_n = shifted[W-1:0];
      quo_n = {quo[W-2:0], 1'b0};
    end else begin
      rem_n = trial[W-1:0];
      quo_n = {quo[W-2:0], 1'b1};
    end
    q_fix = neg_q ? -quo_n : quo_n;
    r_fix = neg_r ? -rem_n : rem_n;
    res   = is_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.rw_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.kill) begin
            is_rem   <= bus.op[1];
            rd       <= bus.rd_in;
            bus.busy <= 1'b1;
            if (div0 || ovf) begin
              // both special cases resolve without iterating
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.wr_en   <= (bus.rd_in != 5'd0);
              bus.rw_addr <= bus.rd_in;
              if (div0) bus.wr_data <= bus.op[1] ? bus.dividend : '1;
              else      bus.wr_data <= bus.op[1] ? '0 : bus.dividend;
            end else begin
              state <= CALC;
              cnt   <= CW'(W);
              rem   <= '0;
              quo   <= a_abs;
              dvsr  <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.wr_en   <= (rd != 5'd0);
              bus.rw_addr <= rd;
              bus.wr_data <= res;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          bus.wr_en   <= 1'b0;
          bus.rw_addr <= '0;
          bus.wr_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
